// File: rtl/bus_arb2.sv
// Two-master round-robin arbiter for the core cmd/rsp bus: posted writes,
// one outstanding read with response routing and a no-response watchdog.
module bus_arb2 #(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic [DW-1:0] m0_cmd_wdata,
    input  logic [AW-1:0] m0_cmd_addr,
    input  logic          m0_cmd_we,
    input  logic [3:0]    m0_cmd_wem,
    input  logic          m0_cmd_valid,
    output logic          m0_cmd_ready,
    output logic [DW-1:0] m0_rsp_rdata,
    output logic          m0_rsp_valid,
    input  logic          m0_rsp_ready,
    output logic          m0_rsp_error,

    input  logic [DW-1:0] m1_cmd_wdata,
    input  logic [AW-1:0] m1_cmd_addr,
    input  logic          m1_cmd_we,
    input  logic [3:0]    m1_cmd_wem,
    input  logic          m1_cmd_valid,
    output logic          m1_cmd_ready,
    output logic [DW-1:0] m1_rsp_rdata,
    output logic          m1_rsp_valid,
    input  logic          m1_rsp_ready,
    output logic          m1_rsp_error,

    output logic [DW-1:0] s_cmd_wdata,
    output logic [AW-1:0] s_cmd_addr,
    output logic          s_cmd_we,
    output logic [3:0]    s_cmd_wem,
    output logic          s_cmd_valid,
    input  logic          s_cmd_ready,
    input  logic [DW-1:0] s_rsp_rdata,
    input  logic          s_rsp_valid,
    output logic          s_rsp_ready,
    input  logic          s_rsp_error,

    output logic          tmo_o
);

    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, WAIT_RSP, TMO} state_t;

    state_t        r_state;
    logic          r_owner;
    logic          r_last;
    logic          r_tmo;
    logic [TW-1:0] r_timer;

    logic w_gnt_vld;
    logic w_gnt;
    logic w_gnt_we;
    logic w_cmd_hs;
    logic w_rsp_hs;
    logic w_own_rdy;
    logic w_limit;

    // Grant is purely combinational; a tie goes to the master not served last.
    assign w_gnt_vld = (r_state == IDLE) && (m0_cmd_valid || m1_cmd_valid);
    assign w_gnt     = (m0_cmd_valid && m1_cmd_valid) ? ~r_last : m1_cmd_valid;
    assign w_gnt_we  = w_gnt ? m1_cmd_we : m0_cmd_we;
    assign w_cmd_hs  = w_gnt_vld && s_cmd_ready;
    assign w_rsp_hs  = s_rsp_valid && s_rsp_ready;
    assign w_own_rdy = r_owner ? m1_rsp_ready : m0_rsp_ready;
    assign w_limit   = (TIMEOUT != 0) && (r_timer == LIMIT);
    assign tmo_o     = r_tmo;

    always_comb begin
        s_cmd_wdata  = '0;
        s_cmd_addr   = '0;
        s_cmd_we     = 1'b0;
        s_cmd_wem    = '0;
        s_cmd_valid  = 1'b0;
        s_rsp_ready  = 1'b0;
        m0_cmd_ready = 1'b0;
        m1_cmd_ready = 1'b0;
        m0_rsp_rdata = '0;
        m0_rsp_valid = 1'b0;
        m0_rsp_error = 1'b0;
        m1_rsp_rdata = '0;
        m1_rsp_valid = 1'b0;
        m1_rsp_error = 1'b0;
        case (r_state)
            IDLE: begin
                // Stray slave responses are swallowed while idle.
                s_rsp_ready = 1'b1;
                if (w_gnt_vld) begin
                    s_cmd_valid = 1'b1;
                    if (w_gnt) begin
                        s_cmd_wdata  = m1_cmd_wdata;
                        s_cmd_addr   = m1_cmd_addr;
                        s_cmd_we     = m1_cmd_we;
                        s_cmd_wem    = m1_cmd_wem;
                        m1_cmd_ready = s_cmd_ready;
                    end else begin
                        s_cmd_wdata  = m0_cmd_wdata;
                        s_cmd_addr   = m0_cmd_addr;
                        s_cmd_we     = m0_cmd_we;
                        s_cmd_wem    = m0_cmd_wem;
                        m0_cmd_ready = s_cmd_ready;
                    end
                end
            end
            WAIT_RSP: begin
                s_rsp_ready = w_own_rdy;
                if (r_owner) begin
                    m1_rsp_valid = s_rsp_valid;
                    m1_rsp_rdata = s_rsp_rdata;
                    m1_rsp_error = s_rsp_error;
                end else begin
                    m0_rsp_valid = s_rsp_valid;
                    m0_rsp_rdata = s_rsp_rdata;
                    m0_rsp_error = s_rsp_error;
                end
            end
            TMO: begin
                // Synthetic error response; a late slave answer is dropped.
                s_rsp_ready = 1'b1;
                if (r_owner) begin
                    m1_rsp_valid = 1'b1;
                    m1_rsp_error = 1'b1;
                end else begin
                    m0_rsp_valid = 1'b1;
                    m0_rsp_error = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_owner <= 1'b0;
            r_last  <= 1'b1;
            r_tmo   <= 1'b0;
            r_timer <= '0;
        end else begin
            r_tmo <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_cmd_hs) begin
                        r_last <= w_gnt;
                        // Writes are posted; only reads hold the bus.
                        if (!w_gnt_we) begin
                            r_owner <= w_gnt;
                            r_timer <= '0;
                            r_state <= WAIT_RSP;
                        end
                    end
                end
                WAIT_RSP: begin
                    if (w_rsp_hs) begin
                        r_state <= IDLE;
                    end else begin
                        if (r_timer != '1)
                            r_timer <= r_timer + 1'b1;
                        if (w_limit) begin
                            r_state <= TMO;
                            r_tmo   <= 1'b1;
                        end
                    end
                end
                TMO: begin
                    if (w_own_rdy)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arb2.sv
// Scoreboard bench for bus_arb2: stimulus queues expected slave commands and
// master responses, a negedge monitor pops and compares on every handshake.
module tb_bus_arb2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] m0_cmd_wdata, m0_cmd_addr, m0_rsp_rdata;
    logic        m0_cmd_we, m0_cmd_valid, m0_cmd_ready, m0_rsp_valid, m0_rsp_ready, m0_rsp_error;
    logic [3:0]  m0_cmd_wem;
    logic [31:0] m1_cmd_wdata, m1_cmd_addr, m1_rsp_rdata;
    logic        m1_cmd_we, m1_cmd_valid, m1_cmd_ready, m1_rsp_valid, m1_rsp_ready, m1_rsp_error;
    logic [3:0]  m1_cmd_wem;
    logic [31:0] s_cmd_wdata, s_cmd_addr, s_rsp_rdata;
    logic        s_cmd_we, s_cmd_valid, s_cmd_ready, s_rsp_valid, s_rsp_ready, s_rsp_error;
    logic [3:0]  s_cmd_wem;
    logic        tmo_o;

    always #5 clk = ~clk;

    bus_arb2 #(.DW(32), .AW(32), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_cmd_wdata(m0_cmd_wdata), .m0_cmd_addr(m0_cmd_addr), .m0_cmd_we(m0_cmd_we),
        .m0_cmd_wem(m0_cmd_wem), .m0_cmd_valid(m0_cmd_valid), .m0_cmd_ready(m0_cmd_ready),
        .m0_rsp_rdata(m0_rsp_rdata), .m0_rsp_valid(m0_rsp_valid), .m0_rsp_ready(m0_rsp_ready),
        .m0_rsp_error(m0_rsp_error),
        .m1_cmd_wdata(m1_cmd_wdata), .m1_cmd_addr(m1_cmd_addr), .m1_cmd_we(m1_cmd_we),
        .m1_cmd_wem(m1_cmd_wem), .m1_cmd_valid(m1_cmd_valid), .m1_cmd_ready(m1_cmd_ready),
        .m1_rsp_rdata(m1_rsp_rdata), .m1_rsp_valid(m1_rsp_valid), .m1_rsp_ready(m1_rsp_ready),
        .m1_rsp_error(m1_rsp_error),
        .s_cmd_wdata(s_cmd_wdata), .s_cmd_addr(s_cmd_addr), .s_cmd_we(s_cmd_we),
        .s_cmd_wem(s_cmd_wem), .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready),
        .s_rsp_rdata(s_rsp_rdata), .s_rsp_valid(s_rsp_valid), .s_rsp_ready(s_rsp_ready),
        .s_rsp_error(s_rsp_error), .tmo_o(tmo_o)
    );

    typedef struct packed {
        logic        mst;
        logic        we;
        logic [3:0]  wem;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cmd_t;

    typedef struct packed {
        logic        mst;
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    cmd_t exp_cmd[$];
    rsp_t exp_rsp[$];
    cmd_t mon_c;
    rsp_t mon_r;
    int   n_chk = 0;
    int   n_err = 0;
    int   n_tmo = 0;

    task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_cmd(logic mst, logic we, logic [31:0] addr, logic [31:0] wdata);
        exp_cmd.push_back(cmd_t'({mst, we, (we ? 4'hF : 4'h0), addr, wdata}));
    endtask

    task automatic push_rsp(logic mst, logic err, logic [31:0] rdata);
        exp_rsp.push_back(rsp_t'({mst, err, rdata}));
    endtask

    task automatic m0_drv(logic v, logic we, logic [31:0] a, logic [31:0] d);
        m0_cmd_valid = v; m0_cmd_we = we; m0_cmd_addr = a; m0_cmd_wdata = d;
        m0_cmd_wem = we ? 4'hF : 4'h0;
    endtask

    task automatic m1_drv(logic v, logic we, logic [31:0] a, logic [31:0] d);
        m1_cmd_valid = v; m1_cmd_we = we; m1_cmd_addr = a; m1_cmd_wdata = d;
        m1_cmd_wem = we ? 4'hF : 4'h0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic rsp_pop(rsp_t act);
        if (exp_rsp.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL rsp_unexpected: got %0h expected none", act);
        end else begin
            chk("rsp", 128'(act), 128'(exp_rsp.pop_front()));
        end
    endtask

    // Monitor: compare every observed handshake against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (s_cmd_valid && s_cmd_ready) begin
                mon_c = cmd_t'({m1_cmd_ready, s_cmd_we, s_cmd_wem, s_cmd_addr, s_cmd_wdata});
                if (exp_cmd.size() == 0) begin
                    n_chk++; n_err++;
                    $display("FAIL cmd_unexpected: got %0h expected none", mon_c);
                end else begin
                    chk("cmd", 128'(mon_c), 128'(exp_cmd.pop_front()));
                end
            end
            if (m0_rsp_valid && m0_rsp_ready) begin
                mon_r = rsp_t'({1'b0, m0_rsp_error, m0_rsp_rdata});
                rsp_pop(mon_r);
            end
            if (m1_rsp_valid && m1_rsp_ready) begin
                mon_r = rsp_t'({1'b1, m1_rsp_error, m1_rsp_rdata});
                rsp_pop(mon_r);
            end
            if (tmo_o) n_tmo++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int i0, i1;
        logic g0;
        i0 = 0; i1 = 0;
        rst_n = 1'b0;
        m0_drv(0, 0, 0, 0); m1_drv(0, 0, 0, 0);
        m0_rsp_ready = 1'b1; m1_rsp_ready = 1'b1;
        s_cmd_ready = 1'b1; s_rsp_valid = 1'b0; s_rsp_rdata = '0; s_rsp_error = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_s_cmd_valid", 128'(s_cmd_valid), 128'(0));
        chk("rst_s_rsp_ready", 128'(s_rsp_ready), 128'(1));
        chk("rst_tmo", 128'(tmo_o), 128'(0));
        chk("rst_rsp_valid", 128'({m0_rsp_valid, m1_rsp_valid}), 128'(0));
        cyc();
        rst_n = 1'b1;

        // Both masters stream writes: m0 wins the first tie, then strict alternation.
        for (int k = 0; k < 6; k++)
            if (k % 2 == 0) push_cmd(0, 1, 32'h100 + 32'(4 * (k / 2)), 32'hA0 + 32'(k / 2));
            else            push_cmd(1, 1, 32'h200 + 32'(4 * (k / 2)), 32'hB0 + 32'(k / 2));
        for (int k = 0; k < 6; k++) begin
            m0_drv(1, 1, 32'h100 + 32'(4 * i0), 32'hA0 + 32'(i0));
            m1_drv(1, 1, 32'h200 + 32'(4 * i1), 32'hB0 + 32'(i1));
            @(negedge clk);
            chk("rr_grant", 128'({m0_cmd_ready, m1_cmd_ready}), 128'((k % 2 == 0) ? 2'b10 : 2'b01));
            g0 = m0_cmd_ready;
            cyc();
            if (g0) i0++; else i1++;
        end
        m0_drv(0, 0, 0, 0); m1_drv(0, 0, 0, 0);

        // m0 read, response on the third cycle after accept.
        m0_drv(1, 0, 32'h1000, 0);
        push_cmd(0, 0, 32'h1000, 0);
        @(negedge clk);
        chk("t1_m0_ready", 128'(m0_cmd_ready), 128'(1));
        cyc();
        m0_drv(0, 0, 0, 0);
        repeat (2) begin
            @(negedge clk);
            chk("t1_no_rsp_yet", 128'({m0_rsp_valid, m1_rsp_valid}), 128'(0));
            cyc();
        end
        s_rsp_valid = 1'b1; s_rsp_rdata = 32'hDEADBEEF;
        push_rsp(0, 0, 32'hDEADBEEF);
        @(negedge clk);
        chk("t1_m1_quiet", 128'(m1_rsp_valid), 128'(0));
        cyc();
        s_rsp_valid = 1'b0; s_rsp_rdata = '0;
        m1_drv(1, 1, 32'h1100, 32'h11);
        push_cmd(1, 1, 32'h1100, 32'h11);
        @(negedge clk);
        chk("t1_idle_next", 128'(m1_cmd_ready), 128'(1));
        cyc();
        m1_drv(0, 0, 0, 0);

        // m1 read pending; m0 write blocked until the response handshake.
        m1_drv(1, 0, 32'h2000, 0);
        push_cmd(1, 0, 32'h2000, 0);
        cyc();
        m1_drv(0, 0, 0, 0);
        m0_drv(1, 1, 32'h3000, 32'h33);
        push_cmd(0, 1, 32'h3000, 32'h33);
        repeat (5) begin
            @(negedge clk);
            chk("t3_m0_blocked", 128'(m0_cmd_ready), 128'(0));
            cyc();
        end
        s_rsp_valid = 1'b1; s_rsp_rdata = 32'h12345678;
        push_rsp(1, 0, 32'h12345678);
        @(negedge clk);
        chk("t3_blocked_at_rsp", 128'({m0_cmd_ready, m0_rsp_valid}), 128'(0));
        cyc();
        s_rsp_valid = 1'b0; s_rsp_rdata = '0;
        @(negedge clk);
        chk("t3_m0_granted", 128'(m0_cmd_ready), 128'(1));
        cyc();
        m0_drv(0, 0, 0, 0);

        // Timeout: slave silent, tmo_o rises 8 edges after accept.
        m0_drv(1, 0, 32'h4000, 0);
        push_cmd(0, 0, 32'h4000, 0);
        m0_rsp_ready = 1'b0;
        cyc();
        m0_drv(0, 0, 0, 0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("t4_no_tmo_early", 128'(tmo_o), 128'(0));
            cyc();
        end
        s_rsp_valid = 1'b1; s_rsp_rdata = 32'hBAD0BAD0;
        @(negedge clk);
        chk("t4_tmo_pulse", 128'(tmo_o), 128'(1));
        chk("t4_err_rsp", 128'({m0_rsp_valid, m0_rsp_error, m0_rsp_rdata}), 128'({1'b1, 1'b1, 32'h0}));
        chk("t4_late_accepted", 128'(s_rsp_ready), 128'(1));
        chk("t4_m1_quiet", 128'(m1_rsp_valid), 128'(0));
        cyc();
        s_rsp_valid = 1'b0; s_rsp_rdata = '0;
        @(negedge clk);
        chk("t4_tmo_single", 128'({tmo_o, m0_rsp_valid}), 128'(2'b01));
        cyc();
        m0_rsp_ready = 1'b1;
        push_rsp(0, 1, 32'h0);
        cyc();
        @(negedge clk);
        chk("t4_idle", 128'(m0_rsp_valid), 128'(0));
        cyc();

        // Response lands exactly at timer == TIMEOUT-1: real data, no timeout.
        m0_drv(1, 0, 32'h5000, 0);
        push_cmd(0, 0, 32'h5000, 0);
        cyc();
        m0_drv(0, 0, 0, 0);
        repeat (7) begin
            @(negedge clk);
            chk("t5_no_tmo", 128'(tmo_o), 128'(0));
            cyc();
        end
        s_rsp_valid = 1'b1; s_rsp_rdata = 32'hCAFEF00D;
        push_rsp(0, 0, 32'hCAFEF00D);
        cyc();
        s_rsp_valid = 1'b0; s_rsp_rdata = '0;
        @(negedge clk);
        chk("t5_no_tmo_after", 128'(tmo_o), 128'(0));
        cyc();

        // Reset during an m1 read: pending response is abandoned.
        m1_drv(1, 0, 32'h6000, 0);
        push_cmd(1, 0, 32'h6000, 0);
        m1_rsp_ready = 1'b0;
        cyc();
        m1_drv(0, 0, 0, 0);
        @(negedge clk);
        chk("t6_wait_rsp_ready", 128'(s_rsp_ready), 128'(0));
        cyc();
        rst_n = 1'b0;
        s_rsp_valid = 1'b1; s_rsp_rdata = 32'h66666666;
        m1_rsp_ready = 1'b1;
        @(negedge clk);
        chk("t6_rst_idle", 128'({s_rsp_ready, m1_rsp_valid, tmo_o}), 128'(3'b100));
        cyc();
        rst_n = 1'b1;
        m0_drv(1, 1, 32'h7000, 32'h70);
        m1_drv(1, 1, 32'h7100, 32'h71);
        push_cmd(0, 1, 32'h7000, 32'h70);
        @(negedge clk);
        chk("t6_m0_wins_tie", 128'({m0_cmd_ready, m1_cmd_ready, m1_rsp_valid}), 128'(3'b100));
        cyc();
        m0_drv(0, 0, 0, 0);
        s_rsp_valid = 1'b0; s_rsp_rdata = '0;
        push_cmd(1, 1, 32'h7100, 32'h71);
        cyc();
        m1_drv(0, 0, 0, 0);
        repeat (2) cyc();

        chk("sb_cmd_drained", 128'(exp_cmd.size()), 128'(0));
        chk("sb_rsp_drained", 128'(exp_rsp.size()), 128'(0));
        chk("tmo_pulse_count", 128'(n_tmo), 128'(1));
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
